// File: rtl/alu_cmd_seq_if.sv
// Request/response handshake bundle for alu_cmd_seq.
// slave = sequencer side, master = command issuer side.
interface alu_cmd_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_cout;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err
    );

    modport master (
        output req_valid, req_cmd, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command sequencer driving an external combinational 32-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_CMD_SEQ_SLT_EN to enable SLT (cmd 111); otherwise cmd 111 is reported illegal.
module alu_cmd_seq (
    input  logic          clk,
    input  logic          rst_n,
    alu_cmd_seq_if.slave  bus,
    output logic [1:0]    alu_op,
    output logic          alu_binvert,
    output logic          alu_cin,
    output logic [31:0]   alu_in1,
    output logic [31:0]   alu_in2,
    input  logic [31:0]   alu_ans,
    input  logic          alu_cout,
    output logic [15:0]   ops_done
);
    localparam logic [2:0] CMD_AND = 3'b000;
    localparam logic [2:0] CMD_OR  = 3'b001;
    localparam logic [2:0] CMD_ADD = 3'b010;
    localparam logic [2:0] CMD_SUB = 3'b110;
`ifdef ALU_CMD_SEQ_SLT_EN
    localparam logic [2:0] CMD_SLT = 3'b111;
`endif

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req_ready_c;
    logic        rsp_valid_c;
    logic        accept;
    logic        cmd_legal;
    logic [1:0]  dec_op;
    logic        dec_inv;
    logic [31:0] exec_data;
    logic [31:0] rsp_data_q;
    logic        rsp_cout_q;
    logic        rsp_err_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cmd_legal = 1'b0;
        dec_op    = OP_AND;
        dec_inv   = 1'b0;
        case (bus.req_cmd)
            CMD_AND: cmd_legal = 1'b1;
            CMD_OR: begin
                cmd_legal = 1'b1;
                dec_op    = OP_OR;
            end
            CMD_ADD: begin
                cmd_legal = 1'b1;
                dec_op    = OP_ADD;
            end
            CMD_SUB: begin
                cmd_legal = 1'b1;
                dec_op    = OP_ADD;
                dec_inv   = 1'b1;
            end
`ifdef ALU_CMD_SEQ_SLT_EN
            CMD_SLT: begin
                cmd_legal = 1'b1;
                dec_op    = OP_ADD;
                dec_inv   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign accept = bus.req_valid && req_ready_c;

    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = cmd_legal ? EXEC : RESP;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = (state == IDLE);
        rsp_valid_c = (state == RESP);
    end

    // ALU drive holds between commands; illegal commands leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op      <= OP_AND;
            alu_binvert <= 1'b0;
            alu_cin     <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
        end else if (accept && cmd_legal) begin
            alu_op      <= dec_op;
            alu_binvert <= dec_inv;
            alu_cin     <= dec_inv;
            alu_in1     <= bus.req_a;
            alu_in2     <= bus.req_b;
        end
    end

`ifdef ALU_CMD_SEQ_SLT_EN
    logic slt_q;
    logic slt_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  slt_q <= 1'b0;
        else if (accept && cmd_legal) slt_q <= (bus.req_cmd == CMD_SLT);
    end

    // Signed less-than: the sign of in1 - in2, corrected when the subtraction overflowed.
    assign slt_ovf   = (alu_in1[31] != alu_in2[31]) && (alu_ans[31] != alu_in1[31]);
    assign exec_data = slt_q ? {31'b0, alu_ans[31] ^ slt_ovf} : alu_ans;
`else
    assign exec_data = alu_ans;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data_q <= exec_data;
            rsp_cout_q <= alu_cout;
            rsp_err_q  <= 1'b0;
        end else if (accept && !cmd_legal) begin
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               ops_done <= '0;
        else if (rsp_valid_c && bus.rsp_ready)    ops_done <= ops_done + 16'd1;
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a behavioural 32-bit ALU on the alu_* ports.
// Build with or without ALU_CMD_SEQ_SLT_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_alu_cmd_seq;
    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        cout;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic        alu_binvert;
    logic        alu_cin;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_ans;
    logic        alu_cout;
    logic [15:0] ops_done;

    alu_cmd_seq_if bus ();

    alu_cmd_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_op      (alu_op),
        .alu_binvert (alu_binvert),
        .alu_cin     (alu_cin),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_ans     (alu_ans),
        .alu_cout    (alu_cout),
        .ops_done    (ops_done)
    );

    always #5 clk = ~clk;

    // Team ALU: AND / OR / add path with optional inversion of in2 and carry-in.
    logic [31:0] alu_b2;
    logic [32:0] alu_sum;
    always_comb begin
        alu_b2   = alu_binvert ? ~alu_in2 : alu_in2;
        alu_sum  = {1'b0, alu_in1} + {1'b0, alu_b2} + {32'b0, alu_cin};
        alu_ans  = alu_sum[31:0];
        alu_cout = 1'b0;
        case (alu_op)
            2'b00:   alu_ans = alu_in1 & alu_b2;
            2'b01:   alu_ans = alu_in1 | alu_b2;
            default: alu_cout = alu_sum[32];
        endcase
    end

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_ops;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [3:0]  last_ctrl;
    exp_t        exp_q[$];
    vec_t        vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e.data = '0;
        e.cout = 1'b0;
        e.err  = 1'b0;
        case (cmd)
            3'b000: e.data = a & b;
            3'b001: e.data = a | b;
            3'b010: begin
                s      = {1'b0, a} + {1'b0, b};
                e.data = s[31:0];
                e.cout = s[32];
            end
            3'b110: begin
                e.data = a - b;
                e.cout = (a >= b);
            end
`ifdef ALU_CMD_SEQ_SLT_EN
            3'b111: begin
                e.data = {31'b0, ($signed(a) < $signed(b))};
                e.cout = (a >= b);
            end
`endif
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // {alu_op, alu_binvert, alu_cin} expected for a legal command.
    function automatic logic [3:0] ctrl_of(input logic [2:0] cmd);
        case (cmd)
            3'b000:  return 4'b0000;
            3'b001:  return 4'b0100;
            3'b010:  return 4'b1000;
            default: return 4'b1011;
        endcase
    endfunction

    task automatic check_reset(input string name);
        check({name, "/rsp_valid"}, bus.rsp_valid, 1'b0);
        check({name, "/req_ready"}, bus.req_ready, 1'b1);
        check({name, "/alu_ctrl"}, {alu_op, alu_binvert, alu_cin}, 4'b0000);
        check({name, "/alu_in"}, {alu_in1, alu_in2}, 64'h0);
        check({name, "/rsp"}, {bus.rsp_data, bus.rsp_cout, bus.rsp_err}, 34'h0);
        check({name, "/ops_done"}, ops_done, 16'h0);
    endtask

    // One command with a busy-time junk request offered and rsp_ready held low for 'hold' cycles.
    task automatic run_cmd(input string name, input logic [2:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input exp_t e, input int hold);
        int   lat;
        exp_t got;
        check({name, "/req_ready"}, bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        exp_q.push_back(e);
        bus.req_cmd = 3'b000;
        bus.req_a   = ~a;
        bus.req_b   = ~b;
        if (!e.err) begin
            last_a    = a;
            last_b    = b;
            last_ctrl = ctrl_of(cmd);
        end
        check({name, "/alu_in"}, {alu_in1, alu_in2}, {last_a, last_b});
        check({name, "/alu_ctrl"}, {alu_op, alu_binvert, alu_cin}, last_ctrl);
        lat = 1;
        while (!bus.rsp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "/latency"}, lat, e.err ? 1 : 2);
        for (int i = 0; i < hold; i++) begin
            check({name, "/hold_hs"}, {bus.rsp_valid, bus.req_ready}, 2'b10);
            check({name, "/hold_data"}, {bus.rsp_data, bus.rsp_cout, bus.rsp_err}, {e.data, e.cout, e.err});
            check({name, "/hold_ops"}, ops_done, exp_ops);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        check({name, "/no_busy_accept"}, alu_in1, last_a);
        got = exp_q.pop_front();
        check({name, "/data"}, bus.rsp_data, got.data);
        check({name, "/cout"}, bus.rsp_cout, got.cout);
        check({name, "/err"}, bus.rsp_err, got.err);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        exp_ops++;
        check({name, "/ops_done"}, ops_done, exp_ops);
        check({name, "/idle"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    task automatic add_vec(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] data, input logic cout, input logic err);
        vecs.push_back('{cmd, a, b, data, cout, err});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [2:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  cmd_pool [5];

        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'b000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        exp_ops       = '0;
        last_a        = '0;
        last_b        = '0;
        last_ctrl     = '0;
        cmd_pool      = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

        add_vec(3'b000, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h00000001, 1'b0, 1'b0);
        add_vec(3'b001, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'hFFFFFFFF, 1'b0, 1'b0);
        add_vec(3'b010, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h00000000, 1'b1, 1'b0);
        add_vec(3'b110, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h4B4B4B4A, 1'b1, 1'b0);
        add_vec(3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        add_vec(3'b010, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0);
        add_vec(3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        add_vec(3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0);
        add_vec(3'b100, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1);
        add_vec(3'b101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1);
`ifdef ALU_CMD_SEQ_SLT_EN
        add_vec(3'b111, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h00000001, 1'b1, 1'b0);
        add_vec(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        add_vec(3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
        add_vec(3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0);
        add_vec(3'b111, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0);
`else
        add_vec(3'b111, 32'hA5A5A5A5, 32'h5A5A5A5B, 32'h00000000, 1'b0, 1'b1);
        add_vec(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
`endif

        #2;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // rsp_ready while idle must not count anything
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check("ready_idle/ops_done", ops_done, exp_ops);
        check("ready_idle/hs", {bus.rsp_valid, bus.req_ready}, 2'b01);

        for (int i = 0; i < vecs.size(); i++) begin
            e.data = vecs[i].data;
            e.cout = vecs[i].cout;
            e.err  = vecs[i].err;
            run_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b, e, i % 3);
        end

        run_cmd("illegal_hold", 3'b011, 32'hDEADBEEF, 32'hCAFEF00D, model(3'b011, 32'hDEADBEEF, 32'hCAFEF00D), 5);

        for (int i = 0; i < 8; i++) begin
            rc = cmd_pool[$urandom_range(0, 4)];
            ra = $urandom;
            rb = $urandom;
            run_cmd($sformatf("rnd%0d", i), rc, ra, rb, model(rc, ra, rb), $urandom_range(0, 2));
        end

        // Back-to-back legal commands: one completion every 3 cycles
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'b010;
        bus.req_a     = 32'h11111111;
        bus.req_b     = 32'h22222222;
        bus.rsp_ready = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd3;
        check("b2b_legal/ops_done", ops_done, exp_ops);
        check("b2b_legal/data", bus.rsp_data, 32'h33333333);
        last_a    = 32'h11111111;
        last_b    = 32'h22222222;
        last_ctrl = 4'b1000;

        // Reset during EXEC
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'b110;
        bus.req_a     = 32'h00000009;
        bus.req_b     = 32'h00000004;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_exec");
        #2 rst_n = 1'b1;
        exp_ops   = '0;
        last_a    = '0;
        last_b    = '0;
        last_ctrl = '0;
        @(posedge clk); #1;

        // Reset during RESP
        run_cmd("pre_rst", 3'b001, 32'h0F0F0000, 32'h0000F0F0, model(3'b001, 32'h0F0F0000, 32'h0000F0F0), 0);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'b010;
        bus.req_a     = 32'h00000007;
        bus.req_b     = 32'h00000008;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_resp/in_resp", {bus.rsp_valid, bus.rsp_data}, {1'b1, 32'h0000000F});
        #2 rst_n = 1'b0;
        #1 check_reset("rst_resp");
        #2 rst_n = 1'b1;
        exp_ops   = '0;
        last_a    = '0;
        last_b    = '0;
        last_ctrl = '0;
        @(posedge clk); #1;

        // 65535 back-to-back illegal transactions (2 cycles each), then one more wraps the counter
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'b011;
        bus.rsp_ready = 1'b1;
        repeat (131070) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("preload/ops_done", ops_done, 16'hFFFF);
        exp_ops = 16'hFFFF;
        run_cmd("wrap", 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, model(3'b000, 32'hFFFF0000, 32'h0F0F0F0F), 1);
        check("wrap/ops_zero", ops_done, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
